restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 131 +++++++++++++
 tb/tb_restoring_divider.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Restoring divider: unsigned WIDTH-bit division, one quotient bit per clock.
// A three-state controller (IDLE, CALC, DONE) sequences a shift/subtract
// datapath. A zero divisor skips CALC and reports an all-ones quotient.
`timescale 1ns/1ps

module restoring_divider #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_by_zero
);

   // Controller states
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // The counter value seen on the final CALC edge
   localparam logic [3:0] LAST_STEP = 4'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [1:0]       w_nextState;
   logic [3:0]       r_count;

   // r_work starts out holding the dividend. Each step shifts its MSB into
   // the partial remainder and shifts the new quotient bit in at the LSB,
   // so after WIDTH steps it holds the complete quotient.
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_divisor;
   logic [WIDTH-1:0] r_partial;

   logic [WIDTH:0]   w_shifted;
   logic [WIDTH:0]   w_trial;
   logic             w_qBit;
   logic [WIDTH-1:0] w_nextPartial;
   logic [WIDTH-1:0] w_nextWork;
   logic             w_accept;
   logic             w_zeroDivisor;
   logic             w_lastStep;

   assign w_accept      = (r_state == IDLE) && i_start;
   assign w_zeroDivisor = (i_divisor == '0);
   assign w_lastStep    = (r_count == LAST_STEP);

   // One restoring step: bring down the next dividend bit and try to subtract
   // the divisor. A clear borrow bit means the subtraction fits.
   assign w_shifted     = {r_partial, r_work[WIDTH-1]};
   assign w_trial       = w_shifted - {1'b0, r_divisor};
   assign w_qBit        = ~w_trial[WIDTH];
   assign w_nextPartial = w_qBit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
   assign w_nextWork    = {r_work[WIDTH-2:0], w_qBit};

   assign o_busy = (r_state == CALC);
   assign o_done = (r_state == DONE);

   // Next-state logic: start is only honoured in IDLE, a zero divisor jumps
   // straight to DONE, and DONE always falls back to IDLE after one cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_nextState = w_zeroDivisor ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_lastStep) begin
               w_nextState = DONE;
            end
         end
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Operand capture on acceptance, then one shift/subtract step per CALC
   // edge. Operands are copied so later input changes cannot disturb the run.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count   <= '0;
         r_work    <= '0;
         r_divisor <= '0;
         r_partial <= '0;
      end else if (w_accept) begin
         r_count   <= '0;
         r_work    <= i_dividend;
         r_divisor <= i_divisor;
         r_partial <= '0;
      end else if (r_state == CALC) begin
         r_count   <= r_count + 4'd1;
         r_work    <= w_nextWork;
         r_partial <= w_nextPartial;
      end
   end

   // Result registers: loaded only when a division finishes (or is rejected
   // for a zero divisor) and otherwise held, so they stay stable during CALC.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_quotient    <= '0;
         o_remainder   <= '0;
         o_div_by_zero <= 1'b0;
      end else if (w_accept && w_zeroDivisor) begin
         o_quotient    <= '1;
         o_remainder   <= i_dividend;
         o_div_by_zero <= 1'b1;
      end else if ((r_state == CALC) && w_lastStep) begin
         o_quotient    <= w_nextWork;
         o_remainder   <= w_nextPartial;
         o_div_by_zero <= 1'b0;
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases, divide by zero,
// ignored start, asynchronous reset abort, back-to-back and a random sweep
// against a plain arithmetic reference model.
`timescale 1ns/1ps

module tb_restoring_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [7:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int vectors     = 0;
   int miscompares = 0;

   restoring_divider #(.WIDTH(8)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_start       (start),
      .i_dividend    (dividend),
      .i_divisor     (divisor),
      .o_busy        (busy),
      .o_done        (done),
      .o_quotient    (quotient),
      .o_remainder   (remainder),
      .o_div_by_zero (div_by_zero)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Watchdog so the run can never hang
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model straight from the arithmetic definition
   task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r, output logic dz);
      if (b == 8'd0) begin
         q  = 8'hFF;
         r  = a;
         dz = 1'b1;
      end else begin
         q  = a / b;
         r  = a % b;
         dz = 1'b0;
      end
   endtask

   // Start one division right after edge N; report after how many edges done
   // was seen (-1 if never), how many sampled cycles busy was high, and
   // whether the result outputs moved while busy.
   task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit scramble,
                          output int doneAt, output int busyCycles, output bit resultMoved);
      logic [7:0] q0;
      logic [7:0] r0;
      logic       dz0;
      @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      q0  = quotient;
      r0  = remainder;
      dz0 = div_by_zero;
      doneAt      = -1;
      busyCycles  = 0;
      resultMoved = 1'b0;
      for (int k = 1; k <= 20 && doneAt < 0; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (scramble) begin
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
         end
         if (busy) begin
            busyCycles++;
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== dz0) resultMoved = 1'b1;
         end
         if (done) doneAt = k;
      end
   endtask

   task automatic test_reset();
      int waited;
      rst      = 1'b1;
      start    = 1'b0;
      dividend = 8'd0;
      divisor  = 8'd0;
      #3;
      vectors++;
      if ({busy, done, div_by_zero} !== 3'b000) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got busy/done/dbz=%b, expected 000", {busy, done, div_by_zero});
      end
      vectors++;
      if ({quotient, remainder} !== 16'h0000) begin
         miscompares++;
         $display("[TB] FAIL reset_results: got q=%0d r=%0d, expected 0 0", quotient, remainder);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      start    = 1'b1;
      dividend = 8'd9;
      divisor  = 8'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL first_edge_accept: got busy=%b, expected 1", busy);
      end
      waited = 0;
      while (done !== 1'b1 && waited < 15) begin
         @(posedge clk);
         #1;
         waited++;
      end
      vectors++;
      if (done !== 1'b1 || quotient !== 8'd3 || remainder !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL first_div: got done=%b q=%0d r=%0d, expected 1 3 0", done, quotient, remainder);
      end
   endtask

   task automatic test_directed();
      logic [7:0] as [6] = '{8'd200, 8'd255, 8'd5,  8'd0, 8'd255, 8'd1};
      logic [7:0] bs [6] = '{8'd7,   8'd1,   8'd10, 8'd3, 8'd255, 8'd255};
      logic [7:0] eq;
      logic [7:0] er;
      logic       edz;
      int  doneAt;
      int  busyCycles;
      bit  moved;
      for (int i = 0; i < 6; i++) begin
         run_div(as[i], bs[i], 1'b0, doneAt, busyCycles, moved);
         ref_div(as[i], bs[i], eq, er, edz);
         vectors++;
         if (doneAt !== 9) begin
            miscompares++;
            $display("[TB] FAIL directed_latency %0d/%0d: got %0d, expected 9", as[i], bs[i], doneAt);
         end
         vectors++;
         if (busyCycles !== 8) begin
            miscompares++;
            $display("[TB] FAIL directed_busy %0d/%0d: got %0d cycles, expected 8", as[i], bs[i], busyCycles);
         end
         vectors++;
         if (quotient !== eq || remainder !== er || div_by_zero !== edz) begin
            miscompares++;
            $display("[TB] FAIL directed_result %0d/%0d: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=%b",
                     as[i], bs[i], quotient, remainder, div_by_zero, eq, er, edz);
         end
         vectors++;
         if (moved !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL directed_hold %0d/%0d: got moved=%b, expected 0", as[i], bs[i], moved);
         end
      end
   endtask

   task automatic test_div_zero();
      int doneAt;
      int busyCycles;
      bit moved;
      run_div(8'd77, 8'd0, 1'b0, doneAt, busyCycles, moved);
      vectors++;
      if (doneAt !== 1 || busyCycles !== 0) begin
         miscompares++;
         $display("[TB] FAIL dz_timing: got done at %0d busy %0d, expected 1 and 0", doneAt, busyCycles);
      end
      vectors++;
      if (quotient !== 8'hFF || remainder !== 8'd77 || div_by_zero !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL dz_result: got q=%0h r=%0d dbz=%b, expected ff 77 1", quotient, remainder, div_by_zero);
      end
      run_div(8'd9, 8'd3, 1'b0, doneAt, busyCycles, moved);
      vectors++;
      if (doneAt !== 9 || quotient !== 8'd3 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL dz_recover: got done at %0d q=%0d r=%0d dbz=%b, expected 9 3 0 0",
                  doneAt, quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_ignore_start();
      int doneCount = 0;
      int doneAt    = -1;
      logic [7:0] gotQ = 8'd0;
      logic [7:0] gotR = 8'd0;
      @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd9;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk);
         #1;
         start = (k == 3);
         if (k == 3) begin
            dividend = 8'd50;
            divisor  = 8'd5;
         end
         if (done) begin
            doneCount++;
            doneAt = k;
            gotQ   = quotient;
            gotR   = remainder;
         end
      end
      vectors++;
      if (doneCount !== 1 || doneAt !== 9) begin
         miscompares++;
         $display("[TB] FAIL ignore_start_done: got %0d pulses last at %0d, expected 1 at 9", doneCount, doneAt);
      end
      vectors++;
      if (gotQ !== 8'd11 || gotR !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL ignore_start_result: got q=%0d r=%0d, expected 11 1", gotQ, gotR);
      end
   endtask

   task automatic test_reset_mid_calc();
      int doneAt;
      int busyCycles;
      bit moved;
      int spurious = 0;
      run_div(8'd200, 8'd7, 1'b0, doneAt, busyCycles, moved);
      @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      vectors++;
      if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 8'd0 || remainder !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: got busy=%b done=%b dbz=%b q=%0d r=%0d, expected all zero",
                  busy, done, div_by_zero, quotient, remainder);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) spurious++;
      end
      vectors++;
      if (spurious !== 0) begin
         miscompares++;
         $display("[TB] FAIL abort_no_done: got %0d active cycles, expected 0", spurious);
      end
      run_div(8'd13, 8'd4, 1'b0, doneAt, busyCycles, moved);
      vectors++;
      if (doneAt !== 9 || quotient !== 8'd3 || remainder !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL after_abort: got done at %0d q=%0d r=%0d, expected 9 3 1", doneAt, quotient, remainder);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] eq;
      logic [7:0] er;
      logic       edz;
      int dones    = 0;
      int lastDone = 0;
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      for (int k = 1; k <= 60 && dones < 4; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            ref_div(a, b, eq, er, edz);
            vectors++;
            if (quotient !== eq || remainder !== er) begin
               miscompares++;
               $display("[TB] FAIL b2b_result %0d/%0d: got q=%0d r=%0d, expected %0d %0d",
                        a, b, quotient, remainder, eq, er);
            end
            vectors++;
            if ((k - lastDone) !== ((dones == 0) ? 9 : 10)) begin
               miscompares++;
               $display("[TB] FAIL b2b_spacing: got %0d edges, expected %0d", k - lastDone, (dones == 0) ? 9 : 10);
            end
            dones++;
            lastDone = k;
            a = 8'($urandom);
            b = 8'($urandom_range(1, 255));
            dividend = a;
            divisor  = b;
            if (dones == 4) start = 1'b0;
         end
      end
      start = 1'b0;
      vectors++;
      if (dones !== 4) begin
         miscompares++;
         $display("[TB] FAIL b2b_count: got %0d done pulses, expected 4", dones);
      end
   endtask

   task automatic test_random();
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] eq;
      logic [7:0] er;
      logic       edz;
      int doneAt;
      int busyCycles;
      bit moved;
      for (int i = 0; i < 3000; i++) begin
         case (i)
            0:       begin a = 8'd0;   b = 8'd255; end
            1:       begin a = 8'd255; b = 8'd255; end
            2:       begin a = 8'd255; b = 8'd0;   end
            3:       begin a = 8'd0;   b = 8'd0;   end
            4:       begin a = 8'd255; b = 8'd2;   end
            default: begin
               a = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom);
               b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            end
         endcase
         run_div(a, b, 1'b1, doneAt, busyCycles, moved);
         ref_div(a, b, eq, er, edz);
         vectors++;
         if (doneAt !== ((b == 8'd0) ? 1 : 9) || moved !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rand_timing %0d/%0d: got done at %0d moved=%b", a, b, doneAt, moved);
         end
         vectors++;
         if (quotient !== eq || remainder !== er || div_by_zero !== edz) begin
            miscompares++;
            $display("[TB] FAIL rand_result %0d/%0d: got q=%0d r=%0d dbz=%b, expected q=%0d r=%0d dbz=%b",
                     a, b, quotient, remainder, div_by_zero, eq, er, edz);
         end
         if (b != 8'd0) begin
            vectors++;
            if ((int'(quotient) * int'(b) + int'(remainder)) !== int'(a) || remainder >= b) begin
               miscompares++;
               $display("[TB] FAIL rand_identity %0d/%0d: got q=%0d r=%0d", a, b, quotient, remainder);
            end
         end
      end
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_directed();
      test_div_zero();
      test_ignore_start();
      test_reset_mid_calc();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
